// File: rtl/asrv32_writeback_commit_pkg.sv
// asrv32_writeback_commit_pkg
//   Shared definitions for the ASRV32 writeback/commit stage: the one-hot
//   opcode bit indices (and the `OPCODE_WIDTH macro used for port widths),
//   load funct3 encodings, trap cause codes and the commit FSM states.
//   No ports; imported by the stage and its load-align sub-module.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

package asrv32_writeback_commit_pkg;

    // One-hot opcode bit positions within i_opcode.
    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;
    localparam int OPCODE_W  = `OPCODE_WIDTH;

    // Load width / signedness select.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Trap cause codes reported on o_trap_cause.
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/asrv32_writeback_commit_load_align.sv
// asrv32_writeback_commit_load_align
//   Combinational load data extraction: picks the byte/half/word addressed by
//   the low address bits, sign- or zero-extends it, and flags misalignment.
//   Ports:
//     i_funct3      load width/sign select (unknown encodings behave as LW)
//     i_lsb         load byte offset
//     i_word        raw memory word
//     o_data        aligned, extended load value
//     o_misaligned  halfword at odd offset or word at non-zero offset

module asrv32_writeback_commit_load_align
    import asrv32_writeback_commit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_lsb,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data,
    output logic            o_misaligned
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign shifted  = i_word >> {i_lsb, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = i_lsb[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_data       = i_word;
        o_misaligned = (i_lsb != 2'b00);
        case (i_funct3)
            F3_LB: begin
                o_data       = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                o_misaligned = 1'b0;
            end
            F3_LBU: begin
                o_data       = {{(XLEN-8){1'b0}}, byte_sel};
                o_misaligned = 1'b0;
            end
            F3_LH: begin
                o_data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                o_misaligned = i_lsb[0];
            end
            F3_LHU: begin
                o_data       = {{(XLEN-16){1'b0}}, half_sel};
                o_misaligned = i_lsb[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/asrv32_writeback_commit.sv
// asrv32_writeback_commit
//   Writeback/commit stage of the ASRV32 core. Accepts one decoded instruction
//   per valid/ready handshake, waits for the load response when needed,
//   computes the next PC with one shared adder, raises misalignment traps and
//   registers the regfile write and architectural PC.
//   Optional build macro: ASRV32_INSTRET_EN adds a 64-bit retired counter on
//   o_instret; without it o_instret is tied to zero.
//   Ports:
//     i_clk, i_rst_n            clock, asynchronous active-low reset
//     i_valid / o_ready         instruction handshake (ready only when idle)
//     i_opcode, i_funct3        one-hot opcode, load width select
//     i_alu_result              ALU result, bit0 = branch taken
//     i_imm, i_rs1_data         immediate, rs1 value
//     i_load_addr_lsb           load byte offset
//     i_load_data, i_load_ack   load response word and its one-cycle strobe
//     o_rd, o_wr_rd_en          writeback data and one-cycle write strobe
//     o_pc                      architectural PC
//     o_commit, o_trap          one-cycle retire and trap pulses
//     o_trap_cause              cause of the most recent trap
//     o_instret                 retired instruction count

module asrv32_writeback_commit
    import asrv32_writeback_commit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PC_RESET    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [XLEN-1:0]          i_alu_result,
    input  logic [XLEN-1:0]          i_imm,
    input  logic [XLEN-1:0]          i_rs1_data,
    input  logic [1:0]               i_load_addr_lsb,
    input  logic [XLEN-1:0]          i_load_data,
    input  logic                     i_load_ack,
    output logic [XLEN-1:0]          o_rd,
    output logic                     o_wr_rd_en,
    output logic [XLEN-1:0]          o_pc,
    output logic                     o_commit,
    output logic                     o_trap,
    output logic [3:0]               o_trap_cause,
    output logic [63:0]              o_instret
);

    state_e          state_q, state_d;
    logic [2:0]      ld_funct3_q;
    logic [1:0]      ld_lsb_q;
    logic            ld_capture;
    logic            commit_now;
    logic            wr_d, trap_d, taken;
    logic [3:0]      cause_d;
    logic [XLEN-1:0] sum, pc_plus4, target, rd_d, pc_d;
    logic [XLEN-1:0] load_data;
    logic            load_misaligned;

    assign o_ready = (state_q == ST_IDLE);

    // One adder serves JALR (rs1 based) and JAL/branch/AUIPC (PC based).
    assign sum      = (i_opcode[OP_JALR] ? i_rs1_data : o_pc) + i_imm;
    assign pc_plus4 = o_pc + XLEN'(4);

    asrv32_writeback_commit_load_align #(.XLEN(XLEN)) u_load_align (
        .i_funct3     (ld_funct3_q),
        .i_lsb        (ld_lsb_q),
        .i_word       (i_load_data),
        .o_data       (load_data),
        .o_misaligned (load_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        ld_capture = 1'b0;
        commit_now = 1'b0;
        taken      = 1'b0;
        target     = sum;
        rd_d       = pc_plus4;
        wr_d       = 1'b1;
        pc_d       = pc_plus4;
        trap_d     = 1'b0;
        cause_d    = CAUSE_INSTR_MISALIGNED;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (i_opcode[OP_LOAD]) begin
                        state_d    = ST_WAIT_LOAD;
                        ld_capture = 1'b1;
                    end else begin
                        commit_now = 1'b1;
                        if (i_opcode[OP_JALR])
                            target = {sum[XLEN-1:1], 1'b0};
                        taken = i_opcode[OP_JAL] | i_opcode[OP_JALR] |
                                (i_opcode[OP_BRANCH] & i_alu_result[0]);
                        if (i_opcode[OP_RTYPE] | i_opcode[OP_ITYPE])
                            rd_d = i_alu_result;
                        else if (i_opcode[OP_LUI])
                            rd_d = i_imm;
                        else if (i_opcode[OP_AUIPC])
                            rd_d = sum;
                        wr_d = ~(i_opcode[OP_BRANCH] | i_opcode[OP_STORE] |
                                 i_opcode[OP_SYSTEM] | i_opcode[OP_FENCE]);
                        if (taken) begin
                            pc_d   = target;
                            trap_d = target[1];
                        end
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (i_load_ack) begin
                    state_d    = ST_IDLE;
                    commit_now = 1'b1;
                    rd_d       = load_data;
                    trap_d     = load_misaligned;
                    cause_d    = CAUSE_LOAD_MISALIGNED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (trap_d) begin
            wr_d = 1'b0;
            pc_d = TRAP_VECTOR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd         <= '0;
            o_wr_rd_en   <= 1'b0;
            o_pc         <= PC_RESET;
            o_commit     <= 1'b0;
            o_trap       <= 1'b0;
            o_trap_cause <= CAUSE_INSTR_MISALIGNED;
            // NOTE: capture registers are reset too; a few flops, and no X
            // can leak into the aligner after an aborted load.
            ld_funct3_q  <= 3'b000;
            ld_lsb_q     <= 2'b00;
        end else begin
            o_commit   <= commit_now;
            o_wr_rd_en <= commit_now & wr_d;
            o_trap     <= commit_now & trap_d;
            if (commit_now) begin
                o_pc <= pc_d;
                if (wr_d)
                    o_rd <= rd_d;
                if (trap_d)
                    o_trap_cause <= cause_d;
            end
            if (ld_capture) begin
                ld_funct3_q <= i_funct3;
                ld_lsb_q    <= i_load_addr_lsb;
            end
        end
    end

`ifdef ASRV32_INSTRET_EN
    logic [63:0] instret_q;

    // Wraps naturally at 2^64.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            instret_q <= 64'd0;
        else if (commit_now && !trap_d)
            instret_q <= instret_q + 64'd1;
    end

    assign o_instret = instret_q;
`else
    assign o_instret = 64'd0;
`endif

endmodule
